// File: rtl/uart_pkg.sv
// Shared types and defaults for the configurable UART receiver.
package uart_pkg;
  localparam int DATA_W_MAX_DEF = 9;
  localparam int OVS_DEF        = 16;

  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_e;

  function automatic parity_e decode_parity(input logic [1:0] p);
    case (p)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Out-of-range widths fall back to the classic 8-bit frame.
  function automatic logic [3:0] decode_bits(input logic [3:0] b);
    return (b >= 4'd5 && b <= 4'd9) ? b : 4'd8;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus 3-sample majority vote around the bit centre.
module uart_rx_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_pin,
  input  logic smp_en,
  input  logic clr,
  output logic rx_sync,
  output logic maj
);
  logic [1:0] sync_q, sync_d;
  logic [1:0] hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[0], rx_pin};
    hist_d = hist_q;
    if (clr)         hist_d = 2'b11;
    else if (smp_en) hist_d = {hist_q[0], sync_q[1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rx_sync = sync_q[1];
  // Third vote is the live synchronised value on the decision tick.
  assign maj = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync) | (hist_q[0] & rx_sync);
endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: per-frame format latch, majority sampling,
// valid/ready holding register with frame/parity/break/overrun status.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int OVS        = OVS_DEF,
  parameter int DATA_W_MAX = DATA_W_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  rx_pin,
  input  logic [3:0]            cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_W_MAX-1:0] rx_data,
  output logic                  rx_frame_err,
  output logic                  rx_parity_err,
  output logic                  rx_break,
  output logic                  rx_overrun
);
  localparam int CW = $clog2(OVS);
  localparam int C  = OVS / 2 - 1;
  localparam logic [CW-1:0] CNT_S0   = CW'(C - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(C);
  localparam logic [CW-1:0] CNT_DEC  = CW'(C + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d, nbits_q, nbits_d;
  parity_e               par_q, par_d;
  logic                  stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic [DATA_W_MAX-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                  dpar_q, dpar_d, ferr_q, ferr_d, perr_q, perr_d, zero_q, zero_d;
  logic                  valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, brk_q, brk_d, ovr_q, ovr_d;
  logic                  rx_sync, maj, decide, wrap, complete, ferr_now, zero_now;

  uart_rx_sampler u_smp (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_pin  (rx_pin),
    .smp_en  (tick && (tick_cnt_q == CNT_S0 || tick_cnt_q == CNT_S1)),
    .clr     (state_q == IDLE),
    .rx_sync (rx_sync),
    .maj     (maj)
  );

  assign decide   = tick && (tick_cnt_q == CNT_DEC);
  assign wrap     = tick && (tick_cnt_q == CNT_LAST);
  assign ferr_now = ferr_q | ~maj;
  assign zero_now = zero_q & ~maj;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    dpar_d     = dpar_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    zero_d     = zero_q;
    complete   = 1'b0;
    if (tick && state_q != IDLE && state_q != BRK_WAIT)
      tick_cnt_d = wrap ? '0 : tick_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (!rx_sync) begin
        state_d    = START;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        nbits_d    = decode_bits(cfg_data_bits);
        par_d      = decode_parity(cfg_parity);
        stop2_d    = cfg_stop2;
        stop_idx_d = 1'b0;
        shreg_d    = '0;
        dpar_d     = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        zero_d     = 1'b1;
      end
      START: begin
        if (decide && maj) state_d = IDLE;
        else if (wrap)     state_d = DATA;
      end
      DATA: begin
        if (decide) begin
          shreg_d[bit_cnt_q] = maj;
          dpar_d = dpar_q ^ maj;
          zero_d = zero_q & ~maj;
        end
        if (wrap) begin
          if (bit_cnt_q == nbits_q - 4'd1)
            state_d = (par_q == PAR_NONE) ? STOP : PARITY;
          else
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY: begin
        if (decide) begin
          perr_d = dpar_q ^ maj ^ (par_q == PAR_ODD);
          zero_d = zero_q & ~maj;
        end
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          ferr_d = ferr_now;
          zero_d = zero_now;
          // Final stop completes mid-bit, leaving half a bit for the next start edge.
          if (!stop2_q || stop_idx_q) begin
            complete = 1'b1;
            state_d  = ferr_now ? BRK_WAIT : IDLE;
          end
        end
        if (wrap) stop_idx_d = 1'b1;
      end
      BRK_WAIT: if (rx_sync) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    brk_d   = brk_q;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
        fe_d    = ferr_now;
        pe_d    = perr_q;
        brk_d   = zero_now;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      dpar_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      dpar_q     <= dpar_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_valid      = valid_q;
  assign rx_data       = data_q;
  assign rx_frame_err  = fe_q;
  assign rx_parity_err = pe_q;
  assign rx_break      = brk_q;
  assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised and directed frames against a frame-level reference model.
module tb_uart_rx_cfg;
  localparam int OVS  = 16;
  localparam int TDIV = 4;

  logic       clk = 1'b0, reset_n = 1'b0, tick = 1'b0, rx_pin = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'd0;
  logic       cfg_stop2 = 1'b0, rx_ready = 1'b0;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_break, rx_overrun;
  logic [8:0] rx_data;

  uart_rx_cfg #(.OVS(OVS), .DATA_W_MAX(9)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .rx_pin(rx_pin),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_break(rx_break), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int unsigned tick_id = 0;
  bit chk_en = 0, rand_ready = 0;
  int acc_cnt = 0, ovr_cnt = 0;
  logic [8:0] last_data = '0;
  logic last_fe = 0, last_pe = 0, last_brk = 0;

  typedef struct {
    int unsigned ctick;
    logic [8:0]  data;
    logic        fe, pe, brk;
  } exp_t;
  exp_t pend[$];
  int m_head = 0;
  logic m_valid, m_ovr, m_fe, m_pe, m_brk;
  logic [8:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div  = (div + 1) % TDIV;
      tick = (div == 0);
      if (div == 0) tick_id++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_ready) rx_ready = ($urandom_range(0, 299) == 0);
  end

  // Holding-register model: a frame lands on its completion tick unless the old one is unread.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 0; m_ovr <= 0; m_data <= '0; m_fe <= 0; m_pe <= 0; m_brk <= 0;
      m_head  <= pend.size();
    end else begin
      m_ovr <= 0;
      if (tick && m_head < pend.size() && pend[m_head].ctick == tick_id) begin
        m_head <= m_head + 1;
        if (!m_valid || rx_ready) begin
          m_valid <= 1;
          m_data  <= pend[m_head].data;
          m_fe    <= pend[m_head].fe;
          m_pe    <= pend[m_head].pe;
          m_brk   <= pend[m_head].brk;
        end else begin
          m_ovr <= 1;
        end
      end else if (m_valid && rx_ready) begin
        m_valid <= 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && chk_en) begin
      chk("valid", 32'(rx_valid), 32'(m_valid));
      chk("overrun", 32'(rx_overrun), 32'(m_ovr));
      chk("data", 32'(rx_data), 32'(m_data));
      chk("frame_err", 32'(rx_frame_err), 32'(m_fe));
      chk("parity_err", 32'(rx_parity_err), 32'(m_pe));
      chk("break", 32'(rx_break), 32'(m_brk));
    end
    if (reset_n && rx_valid && rx_ready) begin
      acc_cnt++;
      last_data = rx_data; last_fe = rx_frame_err; last_pe = rx_parity_err; last_brk = rx_break;
    end
    if (reset_n && rx_overrun) ovr_cnt++;
  end

  task automatic wait_tick();
    do @(posedge clk); while (!tick);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [8:0] d, input logic [3:0] rawbits, input logic [1:0] rawpar,
                            input bit st2, input bit pflip, input bit stop_v, input int glitch_bit,
                            input int extra_low, input bit rdy_pulse, input int abort_bit);
    logic b[$];
    int nb, par, L;
    logic p;
    logic [9:0] msk;
    logic [8:0] dm;
    exp_t e;
    nb  = (rawbits >= 5 && rawbits <= 9) ? int'(rawbits) : 8;
    par = (rawpar == 2'b01) ? 1 : (rawpar == 2'b10) ? 2 : 0;
    msk = (10'd1 << nb) - 10'd1;
    dm  = d & msk[8:0];
    p   = (^dm) ^ (par == 2) ^ pflip;
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) b.push_back(dm[i]);
    if (par != 0) b.push_back(p);
    b.push_back(stop_v);
    if (st2) b.push_back(stop_v);
    L = b.size() - 1;
    e.data = dm;
    e.pe   = (par != 0) && pflip;
    e.fe   = !stop_v;
    e.brk  = (dm == 0) && (par == 0 || p == 1'b0) && !stop_v;
    cfg_data_bits = rawbits; cfg_parity = rawpar; cfg_stop2 = st2;
    wait_tick();
    e.ctick = tick_id + 16 * L + 9;
    if (abort_bit < 0) pend.push_back(e);
    for (int i = 0; i <= L; i++) begin
      rx_pin = b[i];
      if (i == abort_bit) begin
        wait_ticks(5);
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1 rx_pin = 1;
        @(posedge clk);
        #1 reset_n = 1;
        wait_ticks(2 * OVS);
        return;
      end else if (i == L && rdy_pulse) begin
        wait_ticks(8);
        repeat (TDIV - 1) @(posedge clk);
        #1 rx_ready = 1;
        wait_tick();
        rx_ready = 0;
        wait_ticks(OVS - 9);
      end else if (i == glitch_bit) begin
        wait_ticks(7);
        rx_pin = 0;
        wait_tick();
        rx_pin = 1;
        wait_ticks(OVS - 8);
      end else begin
        wait_tick();
        if (i == 0) begin
          cfg_data_bits = 4'($urandom); cfg_parity = 2'($urandom); cfg_stop2 = 1'($urandom);
        end
        wait_ticks(OVS - 1);
      end
    end
    if (extra_low > 0) begin
      rx_pin = 0;
      wait_ticks(OVS * extra_low);
    end
    rx_pin = 1;
    wait_ticks(OVS);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int a0, o0;
    repeat (5) @(posedge clk);
    chk("reset valid", 32'(rx_valid), 0);
    chk("reset data", 32'(rx_data), 0);
    chk("reset overrun", 32'(rx_overrun), 0);
    chk("reset flags", {29'd0, rx_frame_err, rx_parity_err, rx_break}, 0);
    #1 reset_n = 1;
    chk_en = 1;
    wait_ticks(2 * OVS);

    rx_ready = 1;
    a0 = acc_cnt;
    send_frame(9'h0A5, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    chk("8N1 beats", acc_cnt - a0, 1);
    chk("8N1 data", 32'(last_data), 32'h0A5);
    chk("8N1 flags", {29'd0, last_fe, last_pe, last_brk}, 0);

    send_frame(9'h035, 4'd7, 2'b01, 1, 0, 1, -1, 0, 0, -1);
    chk("7E2 data", 32'(last_data), 32'h035);
    chk("7E2 perr0", 32'(last_pe), 0);
    send_frame(9'h035, 4'd7, 2'b01, 1, 1, 1, -1, 0, 0, -1);
    chk("7E2 perr1", 32'(last_pe), 1);
    chk("7E2 data bad par", 32'(last_data), 32'h035);

    send_frame(9'h1FF, 4'd9, 2'b10, 0, 0, 1, -1, 0, 0, -1);
    chk("9O1 data", 32'(last_data), 32'h1FF);
    chk("9O1 perr", 32'(last_pe), 0);
    send_frame(9'h1FF, 4'd5, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    chk("5N1 data", 32'(last_data), 32'h01F);

    a0 = acc_cnt;
    rx_pin = 0; wait_ticks(4); rx_pin = 1; wait_ticks(2 * OVS);
    chk("start glitch beats", acc_cnt - a0, 0);
    send_frame(9'h03C, 4'd8, 2'b00, 0, 0, 1, 3, 0, 0, -1);
    chk("glitch frame data", 32'(last_data), 32'h03C);
    chk("glitch frame beats", acc_cnt - a0, 1);

    a0 = acc_cnt;
    send_frame(9'h000, 4'd8, 2'b00, 0, 0, 0, -1, 2, 0, -1);
    chk("break beats", acc_cnt - a0, 1);
    chk("break flags", {29'd0, last_fe, last_pe, last_brk}, 32'b101);
    send_frame(9'h055, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    chk("after break data", 32'(last_data), 32'h055);
    chk("after break fe", 32'(last_fe), 0);

    rx_ready = 0;
    o0 = ovr_cnt;
    send_frame(9'h011, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    send_frame(9'h022, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    chk("overrun pulses", ovr_cnt - o0, 1);
    chk("overrun kept data", 32'(rx_data), 32'h011);
    send_frame(9'h033, 4'd8, 2'b00, 0, 0, 1, -1, 0, 1, -1);
    chk("accept+load no overrun", ovr_cnt - o0, 1);
    chk("accept+load data", 32'(rx_data), 32'h033);
    chk("accept+load valid", 32'(rx_valid), 1);
    rx_ready = 1;
    wait_ticks(4);

    rx_ready = 0;
    send_frame(9'h044, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    send_frame(9'h077, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, 4);
    chk("abort valid", 32'(rx_valid), 0);
    chk("abort data", 32'(rx_data), 0);
    rx_ready = 1;
    send_frame(9'h05A, 4'd8, 2'b00, 0, 0, 1, -1, 0, 0, -1);
    chk("post-abort data", 32'(last_data), 32'h05A);

    rand_ready = 1;
    for (int n = 0; n < 30; n++) begin
      logic [8:0] d;
      d = 9'($urandom);
      if ($urandom_range(0, 9) == 0) d = '0;
      send_frame(d, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) != 0, -1, 0, 0, -1);
      wait_ticks($urandom_range(0, 5));
    end
    rand_ready = 0;
    @(negedge clk);
    rx_ready = 1;
    wait_ticks(2 * OVS);
    chk("model drained", 32'(m_head), 32'(pend.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
